// File: rtl/match_pair_collector.sv
// Receives MATCH_Top pairs, buffers them in a FWFT FIFO, and reports per-frame pair counts.
// Optional input depth filter enabled by defining MATCH_COLLECT_DEPTH_FILTER_EN.
module match_pair_collector #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 12,
  parameter logic [15:0] MAX_DEPTH  = 16'd10000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  input  logic             i_valid,
  input  logic [9:0]       i_src_coor_x,
  input  logic [9:0]       i_src_coor_y,
  input  logic [15:0]      i_src_depth,
  input  logic [9:0]       i_dst_coor_x,
  input  logic [9:0]       i_dst_coor_y,
  input  logic [15:0]      i_dst_depth,
  output logic             o_pair_valid,
  input  logic             i_pair_ready,
  output logic [9:0]       o_src_coor_x,
  output logic [9:0]       o_src_coor_y,
  output logic [15:0]      o_src_depth,
  output logic [9:0]       o_dst_coor_x,
  output logic [9:0]       o_dst_coor_y,
  output logic [15:0]      o_dst_depth,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_pairs,
  output logic             o_overflow,
  output logic             o_proto_err,
`ifdef MATCH_COLLECT_DEPTH_FILTER_EN
  output logic [CNT_W-1:0] o_filtered_cnt,
`endif
  output logic             o_busy
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned DW      = 72;
  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, end_cnt_q, end_cnt_d, out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] frame_pairs_q, frame_pairs_d, in_base;
  logic             end_pending_q, end_pending_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic          cand, empty, full, pop, push, drop, done_cond;
  logic [DW-1:0] wr_data, head;

`ifdef MATCH_COLLECT_DEPTH_FILTER_EN
  logic             depth_ok, filt;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d, filt_base;

  assign depth_ok = (i_src_depth != 16'd0) && (i_dst_depth != 16'd0) &&
                    (i_src_depth <= MAX_DEPTH) && (i_dst_depth <= MAX_DEPTH);
  assign cand     = i_valid && depth_ok;
  assign filt     = i_valid && !depth_ok;

  always_comb begin
    filt_base  = i_frame_start ? '0 : filt_cnt_q;
    filt_cnt_d = (filt && filt_base != CntMax) ? filt_base + CNT_W'(1) : filt_base;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) filt_cnt_q <= '0;
    else          filt_cnt_q <= filt_cnt_d;
  end

  assign o_filtered_cnt = filt_cnt_q;
`else
  logic unused_max_depth;
  assign unused_max_depth = ^MAX_DEPTH;
  assign cand             = i_valid;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign pop   = !empty && i_pair_ready;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push  = cand && (!full || pop);
  assign drop  = cand && full && !pop;

  assign wr_data = {i_src_coor_x, i_src_coor_y, i_src_depth,
                    i_dst_coor_x, i_dst_coor_y, i_dst_depth};
  assign head    = mem_q[rd_ptr_q];

  assign done_cond = end_pending_q && (out_cnt_q == end_cnt_q);

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    in_base       = i_frame_start ? '0 : in_cnt_q;
    in_cnt_d      = (push && in_base != CntMax) ? in_base + CNT_W'(1) : in_base;

    overflow_d    = overflow_q;
    if (i_frame_start) overflow_d = drop;
    else if (drop)     overflow_d = 1'b1;

    end_pending_d = end_pending_q;
    end_cnt_d     = end_cnt_q;
    proto_err_d   = proto_err_q;
    if (done_cond) end_pending_d = 1'b0;
    if (i_frame_end) begin
      if (!end_pending_q) begin
        end_pending_d = 1'b1;
        end_cnt_d     = in_cnt_d;
      end else begin
        proto_err_d   = 1'b1;
      end
    end

    // A pop in the done cycle already belongs to the next frame.
    out_cnt_d = out_cnt_q;
    if (done_cond) out_cnt_d = pop ? CNT_W'(1) : '0;
    else if (pop)  out_cnt_d = out_cnt_q + CNT_W'(1);

    frame_done_d  = done_cond;
    frame_pairs_d = done_cond ? end_cnt_q : frame_pairs_q;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_cnt_q      <= '0;
      end_cnt_q     <= '0;
      out_cnt_q     <= '0;
      frame_pairs_q <= '0;
      end_pending_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_cnt_q      <= in_cnt_d;
      end_cnt_q     <= end_cnt_d;
      out_cnt_q     <= out_cnt_d;
      frame_pairs_q <= frame_pairs_d;
      end_pending_q <= end_pending_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign o_pair_valid  = !empty;
  assign o_src_coor_x  = empty ? '0 : head[71:62];
  assign o_src_coor_y  = empty ? '0 : head[61:52];
  assign o_src_depth   = empty ? '0 : head[51:36];
  assign o_dst_coor_x  = empty ? '0 : head[35:26];
  assign o_dst_coor_y  = empty ? '0 : head[25:16];
  assign o_dst_depth   = empty ? '0 : head[15:0];
  assign o_frame_done  = frame_done_q;
  assign o_frame_pairs = frame_pairs_q;
  assign o_overflow    = overflow_q;
  assign o_proto_err   = proto_err_q;
  assign o_busy        = !empty || end_pending_q;

endmodule
